// File: rtl/spcore_pkg.sv
// Shared definitions for the spcore_seq streaming-processor lane: opcodes,
// FSM states, SETP compare codes and the register-index width helper.
package spcore_pkg;

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_LOADI    = 4'd1;
  localparam logic [3:0] OP_ADD      = 4'd2;
  localparam logic [3:0] OP_SUB      = 4'd3;
  localparam logic [3:0] OP_MUL      = 4'd4;
  localparam logic [3:0] OP_MAD      = 4'd5;
  localparam logic [3:0] OP_LOADC_ID = 4'd6;
  localparam logic [3:0] OP_LOADC_N  = 4'd7;
  localparam logic [3:0] OP_CLEAR    = 4'd8;
  localparam logic [3:0] OP_INC      = 4'd9;
  localparam logic [3:0] OP_SETP     = 4'd10;
  localparam logic [3:0] OP_LOAD     = 4'd11;
  localparam logic [3:0] OP_STORE    = 4'd12;

  localparam logic [1:0] CMP_EQ  = 2'd0;
  localparam logic [1:0] CMP_NEQ = 2'd1;
  localparam logic [1:0] CMP_LTU = 2'd2;
  localparam logic [1:0] CMP_GEU = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  function automatic int ra_width(input int nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

  // Ops that retire by writing R[x]; SETP only touches P, STORE only memory.
  function automatic logic writes_reg(input logic [3:0] op);
    return ((op >= OP_LOADI) && (op <= OP_INC)) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/spcore_alu.sv
// Combinational ALU and comparator for spcore_seq.
// Define SPCORE_SAT_EN to make ADD/INC/MUL/MAD saturate high and SUB saturate at 0.
module spcore_alu
  import spcore_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CORE_ID = 0,
  parameter int N_CORES = 1
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] res,
  output logic              cmp
);

`ifdef SPCORE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [DATA_W-1:0] MAXV = '1;

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     sum_add;
  logic [DATA_W:0]     diff_sub;
  logic [DATA_W:0]     sum_mad;
  logic [DATA_W:0]     sum_inc;
  logic                mul_ovf;

  // Extra top bit on every sum/difference is the carry or borrow.
  assign prod     = b * c;
  assign mul_ovf  = |prod[2*DATA_W-1:DATA_W];
  assign sum_add  = {1'b0, b} + {1'b0, c};
  assign diff_sub = {1'b0, b} - {1'b0, c};
  assign sum_mad  = {1'b0, a} + {1'b0, prod[DATA_W-1:0]};
  assign sum_inc  = {1'b0, a} + (DATA_W+1)'(1);

  always_comb begin
    res = '0;
    cmp = 1'b0;
    case (imm[1:0])
      CMP_EQ:  cmp = (a == b);
      CMP_NEQ: cmp = (a != b);
      CMP_LTU: cmp = (a < b);
      CMP_GEU: cmp = (a >= b);
      default: cmp = 1'b0;
    endcase
    case (op)
      OP_LOADI:    res = imm;
      OP_ADD:      res = (SAT_EN && sum_add[DATA_W]) ? MAXV : sum_add[DATA_W-1:0];
      OP_SUB:      res = (SAT_EN && diff_sub[DATA_W]) ? '0 : diff_sub[DATA_W-1:0];
      OP_MUL:      res = (SAT_EN && mul_ovf) ? MAXV : prod[DATA_W-1:0];
      OP_MAD:      res = (SAT_EN && (mul_ovf || sum_mad[DATA_W])) ? MAXV : sum_mad[DATA_W-1:0];
      OP_LOADC_ID: res = DATA_W'(CORE_ID);
      OP_LOADC_N:  res = DATA_W'(N_CORES);
      OP_CLEAR:    res = '0;
      OP_INC:      res = (SAT_EN && sum_inc[DATA_W]) ? MAXV : sum_inc[DATA_W-1:0];
      OP_SETP:     res = DATA_W'(cmp);
      OP_STORE:    res = a;
      default:     res = '0;
    endcase
  end

endmodule

// File: rtl/spcore_seq.sv
// Self-sequencing SP lane: IDLE/READ/EXEC/MEM/WB FSM, register file, predicate P.
// Optional saturating arithmetic via the SPCORE_SAT_EN macro (inside spcore_alu).
module spcore_seq
  import spcore_pkg::*;
#(
  parameter int  DATA_W  = 16,
  parameter int  NREG    = 16,
  parameter int  CORE_ID = 0,
  parameter int  N_CORES = 1,
  localparam int RA_W    = ra_width(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic              guard,
  input  logic [RA_W-1:0]   rx,
  input  logic [RA_W-1:0]   ry,
  input  logic [RA_W-1:0]   rz,
  input  logic [DATA_W-1:0] imm,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              pred,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            state_reg;
  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        op_reg;
  logic              guard_reg;
  logic [RA_W-1:0]   x_reg, y_reg, z_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] a_reg, b_reg, c_reg;
  logic              cmp_reg;
  logic              squash_reg;
  logic              pred_reg;
  logic              ready_reg;
  logic              done_reg;
  logic [DATA_W-1:0] result_reg;
  logic              mem_req_reg, mem_we_reg;
  logic [DATA_W-1:0] mem_addr_reg, mem_wdata_reg;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cmp;
  logic              squash_next;
  logic              is_mem_op;
  logic              wb_we;

  spcore_alu #(
    .DATA_W  (DATA_W),
    .CORE_ID (CORE_ID),
    .N_CORES (N_CORES)
  ) u_alu (
    .op  (op_reg),
    .a   (a_reg),
    .b   (b_reg),
    .c   (c_reg),
    .imm (imm_reg),
    .res (alu_res),
    .cmp (alu_cmp)
  );

  assign squash_next = guard_reg && !pred_reg;
  assign is_mem_op   = (op_reg == OP_LOAD) || (op_reg == OP_STORE);
  assign wb_we       = (state_reg == ST_WB) && !squash_reg && writes_reg(op_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[x_reg] <= result_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_NOP;
      guard_reg     <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      imm_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      cmp_reg       <= 1'b0;
      squash_reg    <= 1'b0;
      pred_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid && ready_reg) begin
            op_reg    <= opcode;
            guard_reg <= guard;
            x_reg     <= rx;
            y_reg     <= ry;
            z_reg     <= rz;
            imm_reg   <= imm;
            ready_reg <= 1'b0;
            state_reg <= ST_READ;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        ST_READ: begin
          a_reg     <= regs[x_reg];
          b_reg     <= regs[y_reg];
          c_reg     <= regs[z_reg];
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          cmp_reg    <= alu_cmp;
          squash_reg <= squash_next;
          // Squashed memory ops skip the bus and retire with the ALU value.
          if (is_mem_op && !squash_next) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= (op_reg == OP_STORE);
            mem_addr_reg  <= b_reg;
            mem_wdata_reg <= a_reg;
            state_reg     <= ST_MEM;
          end else begin
            result_reg <= alu_res;
            done_reg   <= 1'b1;
            state_reg  <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            result_reg  <= (op_reg == OP_LOAD) ? mem_rdata : alu_res;
            done_reg    <= 1'b1;
            state_reg   <= ST_WB;
          end
        end
        ST_WB: begin
          done_reg <= 1'b0;
          if (!squash_reg && (op_reg == OP_SETP)) pred_reg <= cmp_reg;
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = ready_reg;
  assign done        = done_reg;
  assign result      = result_reg;
  assign pred        = pred_reg;
  assign mem_req     = mem_req_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_spcore_seq.sv
// Directed self-checking bench for spcore_seq (DATA_W=16, NREG=16, CORE_ID=100, N_CORES=4).
// Expected arithmetic follows SPCORE_SAT_EN when the build defines it.
module tb_spcore_seq;
  import spcore_pkg::*;

`ifdef SPCORE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  opcode = '0;
  logic        guard = 1'b0;
  logic [3:0]  rx = '0, ry = '0, rz = '0;
  logic [15:0] imm = '0;
  logic        done;
  logic [15:0] result;
  logic        pred;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spcore_seq #(
    .DATA_W  (16),
    .NREG    (16),
    .CORE_ID (100),
    .N_CORES (4)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .guard       (guard),
    .rx          (rx),
    .ry          (ry),
    .rz          (rz),
    .imm         (imm),
    .done        (done),
    .result      (result),
    .pred        (pred),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic g, input logic [3:0] x,
                       input logic [3:0] y, input logic [3:0] z, input logic [15:0] im);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 1);
    opcode = o; guard = g; rx = x; ry = y; rz = z; imm = im;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Non-memory op: done must appear exactly in the third cycle after accept.
  task automatic run_op(input string tag, input logic [3:0] o, input logic g,
                        input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                        input logic [15:0] im, input bit chk_res, input logic [15:0] exp_res);
    issue(o, g, x, y, z, im);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk({tag, "_rdy"}, 32'(instr_ready), 0);
      chk({tag, "_done"}, 32'(done), 32'(k == 3));
      chk({tag, "_mreq"}, 32'(mem_req), 0);
    end
    if (chk_res) chk({tag, "_res"}, 32'(result), 32'(exp_res));
    $display("op=%0d tag=%s result=%0d pred=%0b", o, tag, result, pred);
    @(negedge clk);
    chk({tag, "_done_off"}, 32'(done), 0);
    chk({tag, "_rdy_back"}, 32'(instr_ready), 1);
  endtask

  task automatic mem_op(input string tag, input logic [3:0] o, input logic [3:0] x,
                        input logic [3:0] y, input int delay, input logic [15:0] rdata,
                        input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                        input bit is_load, input logic [15:0] exp_res);
    int n = 0;
    issue(o, 1'b0, x, y, 4'd0, 16'd0);
    @(negedge clk);
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_seen"}, 32'(mem_req), 1);
    for (int i = 0; i <= delay; i++) begin
      chk({tag, "_req"}, 32'(mem_req), 1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'(exp_wdata));
      chk({tag, "_we"}, 32'(mem_we), 32'(!is_load));
      chk({tag, "_early_done"}, 32'(done), 0);
      if (i == delay) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    mem_rdata = 16'hDEAD;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_req_off"}, 32'(mem_req), 0);
    if (is_load) chk({tag, "_res"}, 32'(result), 32'(exp_res));
    $display("op=%0d tag=%s addr=%0d result=%0d", o, tag, exp_addr, result);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mreq", 32'(mem_req), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_pred", 32'(pred), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(instr_ready), 1);

    // Basic ops and timing
    run_op("loadi_r0", OP_LOADI, 0, 0, 0, 0, 16'd11, 1, 16'd11);
    run_op("loadi_r1", OP_LOADI, 0, 1, 0, 0, 16'd20, 1, 16'd20);
    run_op("add_r2", OP_ADD, 0, 2, 0, 1, 16'd0, 1, 16'd31);
    run_op("mad_r2", OP_MAD, 0, 2, 0, 1, 16'd0, 1, 16'd251);
    run_op("inc_r3", OP_INC, 0, 3, 0, 0, 16'd0, 1, 16'd1);
    run_op("ldid_r4", OP_LOADC_ID, 0, 4, 0, 0, 16'd0, 1, 16'd100);
    run_op("ldn_r5", OP_LOADC_N, 0, 5, 0, 0, 16'd0, 1, 16'd4);

    // Wrap / saturate boundaries
    run_op("loadi_r6", OP_LOADI, 0, 6, 0, 0, 16'd300, 1, 16'd300);
    run_op("loadi_r7", OP_LOADI, 0, 7, 0, 0, 16'd300, 1, 16'd300);
    run_op("mul_r8", OP_MUL, 0, 8, 6, 7, 16'd0, 1, SAT ? 16'd65535 : 16'd24464);
    run_op("clear_r9", OP_CLEAR, 0, 9, 0, 0, 16'd0, 1, 16'd0);
    run_op("loadi_r10", OP_LOADI, 0, 10, 0, 0, 16'd1, 1, 16'd1);
    run_op("sub_r11", OP_SUB, 0, 11, 9, 10, 16'd0, 1, SAT ? 16'd0 : 16'd65535);
    run_op("loadi_ffff", OP_LOADI, 0, 13, 0, 0, 16'hFFFF, 1, 16'hFFFF);
    run_op("inc_ffff", OP_INC, 0, 13, 0, 0, 16'd0, 1, SAT ? 16'hFFFF : 16'd0);

    // Predicate and guarded execution
    run_op("setp_neq", OP_SETP, 0, 1, 1, 0, 16'd1, 0, 16'd0);
    chk("pred_neq", 32'(pred), 0);
    run_op("g_loadi_sq", OP_LOADI, 1, 3, 0, 0, 16'd7, 1, 16'd7);
    run_op("r3_kept", OP_ADD, 0, 12, 3, 9, 16'd0, 1, 16'd1);
    run_op("g_store_sq", OP_STORE, 1, 2, 0, 0, 16'd0, 0, 16'd0);
    run_op("setp_ltu_f", OP_SETP, 0, 1, 0, 0, 16'd2, 0, 16'd0);
    chk("pred_ltu_f", 32'(pred), 0);
    run_op("setp_geu", OP_SETP, 0, 1, 0, 0, 16'd3, 0, 16'd0);
    chk("pred_geu", 32'(pred), 1);
    run_op("setp_eq", OP_SETP, 0, 1, 1, 0, 16'd0, 0, 16'd0);
    chk("pred_eq", 32'(pred), 1);
    run_op("g_loadi_ok", OP_LOADI, 1, 3, 0, 0, 16'd7, 1, 16'd7);
    run_op("r3_written", OP_ADD, 0, 12, 3, 9, 16'd0, 1, 16'd7);
    run_op("setp_ltu_t", OP_SETP, 0, 0, 1, 0, 16'd2, 0, 16'd0);
    chk("pred_ltu_t", 32'(pred), 1);

    // Memory port
    mem_op("store", OP_STORE, 2, 0, 3, 16'd0, 16'd11, 16'd251, 0, 16'd0);
    mem_op("load", OP_LOAD, 4, 0, 1, 16'd251, 16'd11, 16'd100, 1, 16'd251);
    run_op("r4_loaded", OP_ADD, 0, 12, 4, 9, 16'd0, 1, 16'd251);

    // Reset while waiting in MEM
    issue(OP_STORE, 1'b0, 4'd2, 4'd0, 4'd0, 16'd0);
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mrst_req_seen", 32'(mem_req), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_req", 32'(mem_req), 0);
    chk("mrst_ready", 32'(instr_ready), 0);
    chk("mrst_addr", 32'(mem_addr), 0);
    chk("mrst_wdata", 32'(mem_wdata), 0);
    chk("mrst_pred", 32'(pred), 0);
    chk("mrst_result", 32'(result), 0);
    @(negedge clk);
    chk("mrst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_rel_ready", 32'(instr_ready), 1);
    $display("reset during MEM applied and released");
    run_op("post_r2_r4", OP_ADD, 0, 12, 2, 4, 16'd0, 1, 16'd0);
    run_op("post_r0_r1", OP_ADD, 0, 12, 0, 1, 16'd0, 1, 16'd0);
    chk("post_pred", 32'(pred), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
